// File: rtl/fpu_pkg.sv
// Shared FPU definitions for the float-to-int converter.
// Holds the rounding-mode enum, float32 field constants and layout, and the
// payload that travels from the decode/shift stage to the round stage.
// FTOI_RNE_EN: when defined, guard/sticky/rm travel with the payload so that
// round-to-nearest-even is possible; when undefined the converter is RTZ only.
package fpu_pkg;

  localparam int EXP_W  = 8;
  localparam int FRAC_W = 23;
  localparam int BIAS   = 127;
  localparam int MAG_W  = 32;

  typedef enum logic {
    RM_RTZ = 1'b0,
    RM_RNE = 1'b1
  } rm_t;

  typedef struct packed {
    logic              sign;
    logic [EXP_W-1:0]  exp;
    logic [FRAC_W-1:0] frac;
  } f32_t;

  // Integer magnitude plus the bits needed to finish the conversion later.
  // sat: magnitude certainly exceeds any output range (or Inf).
  typedef struct packed {
    logic             sign;
    logic             nan;
    logic             sat;
    logic [MAG_W-1:0] mag;
`ifdef FTOI_RNE_EN
    logic             guard;
    logic             sticky;
    rm_t              rm;
`endif
  } ftoi_pl_t;

endpackage

// File: rtl/ftoi_round.sv
// Combinational round / negate / saturate for the last converter stage.
// Ports:
//   pl_i      payload from the decode/shift stage
//   result_o  signed OUT_W-bit integer
//   ovf_o     magnitude out of range, result saturated
//   inv_o     NaN input, result forced to max positive
// FTOI_RNE_EN: enables the RNE increment; otherwise truncation only.
module ftoi_round
  import fpu_pkg::*;
#(
  parameter int OUT_W = 32
) (
  input  ftoi_pl_t         pl_i,
  output logic [OUT_W-1:0] result_o,
  output logic             ovf_o,
  output logic             inv_o
);

  localparam logic [MAG_W:0]   ONE     = 1;
  localparam logic [MAG_W:0]   LIM_NEG = ONE << (OUT_W - 1);
  localparam logic [MAG_W:0]   LIM_POS = LIM_NEG - ONE;
  localparam logic [OUT_W-1:0] MAX_RES = {1'b0, {(OUT_W-1){1'b1}}};
  localparam logic [OUT_W-1:0] MIN_RES = {1'b1, {(OUT_W-1){1'b0}}};

  logic             inc;
  logic [MAG_W:0]   mag_r;
  logic [OUT_W-1:0] mag_lo;

`ifdef FTOI_RNE_EN
  // Round up above half, or on an exact half when the kept LSB is odd.
  assign inc = (pl_i.rm == RM_RNE) && pl_i.guard && (pl_i.sticky || pl_i.mag[0]);
`else
  assign inc = 1'b0;
`endif

  assign mag_r  = {1'b0, pl_i.mag} + {{MAG_W{1'b0}}, inc};
  assign mag_lo = mag_r[OUT_W-1:0];

  always_comb begin
    result_o = '0;
    ovf_o    = 1'b0;
    inv_o    = 1'b0;
    if (pl_i.nan) begin
      result_o = MAX_RES;
      inv_o    = 1'b1;
    end else if (pl_i.sat || (!pl_i.sign && mag_r > LIM_POS) ||
                 (pl_i.sign && mag_r > LIM_NEG)) begin
      result_o = pl_i.sign ? MIN_RES : MAX_RES;
      ovf_o    = 1'b1;
    end else if (pl_i.sign) begin
      result_o = -mag_lo;
    end else begin
      result_o = mag_lo;
    end
  end

endmodule

// File: rtl/ftoi_pipe.sv
// Pipelined float32 -> signed OUT_W-bit integer converter, valid/ready.
// Ports:
//   clk, reset            clock, async active-low reset
//   in_valid/in_ready     input handshake for op1/rm
//   op1, rm               float32 operand, rounding mode (0 RTZ, 1 RNE)
//   out_valid/out_ready   output handshake
//   result, ovf, inv      integer result, saturation flag, NaN flag
// Parameters: OUT_W (16..32), STAGES (1..4, unstalled latency).
// FTOI_RNE_EN: when undefined rm is ignored and everything truncates.
module ftoi_pipe
  import fpu_pkg::*;
#(
  parameter int OUT_W  = 32,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      op1,
  input  logic             rm,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] result,
  output logic             ovf,
  output logic             inv
);

  localparam logic signed [9:0] E_SAT = 10'(OUT_W);

  logic             advance;
  f32_t             f;
  logic signed [9:0] e;
  logic [5:0]       sh;
  logic [56:0]      wide;
  ftoi_pl_t         s1_pl;
  ftoi_pl_t         last_pl;
  logic             last_v;
  logic [OUT_W-1:0] res_d;
  logic             ovf_d, inv_d;
  logic             out_valid_q, ovf_q, inv_q;
  logic [OUT_W-1:0] result_q;

  assign advance  = !out_valid_q || out_ready;
  assign in_ready = advance;

  // Fixed point with 25 fraction bits: bit 24 is guard, 23:0 feed sticky.
  // Only used for -1 <= e <= OUT_W-1, so the shift stays within 57 bits.
  assign f    = op1;
  assign e    = $signed({2'b00, f.exp}) - 10'(BIAS);
  assign sh   = 6'(e + 10'sd2);
  assign wide = {33'd0, 1'b1, f.frac} << sh;

`ifndef FTOI_RNE_EN
  logic unused_low;
  assign unused_low = ^{wide[24:0], rm};
`endif

  always_comb begin
    s1_pl      = '0;
    s1_pl.sign = f.sign;
`ifdef FTOI_RNE_EN
    s1_pl.rm   = rm_t'(rm);
`endif
    if (f.exp == '1) begin
      s1_pl.nan = |f.frac;
      s1_pl.sat = ~|f.frac;
    end else if (f.exp != '0) begin
      if (e >= E_SAT) begin
        s1_pl.sat = 1'b1;
      end else if (e >= -10'sd1) begin
        s1_pl.mag = wide[56:25];
`ifdef FTOI_RNE_EN
        s1_pl.guard  = wide[24];
        s1_pl.sticky = |wide[23:0];
      end else begin
        // Below 0.5: never rounds up, but must not look like an exact tie.
        s1_pl.sticky = 1'b1;
`endif
      end
    end
  end

  if (STAGES == 1) begin : g_comb
    assign last_pl = s1_pl;
    assign last_v  = in_valid;
  end else begin : g_regs
    ftoi_pl_t          pl_q [STAGES-1];
    logic [STAGES-2:0] v_q;

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        v_q <= '0;
        for (int i = 0; i < STAGES - 1; i++) pl_q[i] <= '0;
      end else if (advance) begin
        v_q[0]  <= in_valid;
        pl_q[0] <= s1_pl;
        for (int i = 1; i < STAGES - 1; i++) begin
          v_q[i]  <= v_q[i-1];
          pl_q[i] <= pl_q[i-1];
        end
      end
    end

    assign last_pl = pl_q[STAGES-2];
    assign last_v  = v_q[STAGES-2];
  end

  ftoi_round #(.OUT_W(OUT_W)) u_round (
    .pl_i     (last_pl),
    .result_o (res_d),
    .ovf_o    (ovf_d),
    .inv_o    (inv_d)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_valid_q <= 1'b0;
      result_q    <= '0;
      ovf_q       <= 1'b0;
      inv_q       <= 1'b0;
    end else if (advance) begin
      out_valid_q <= last_v;
      result_q    <= last_v ? res_d : '0;
      ovf_q       <= last_v & ovf_d;
      inv_q       <= last_v & inv_d;
    end
  end

  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign ovf       = ovf_q;
  assign inv       = inv_q;

endmodule

// File: tb/tb_ftoi_pipe.sv
`timescale 1ns/1ps
module tb_ftoi_pipe;

`ifdef FTOI_RNE_EN
  localparam bit RNE = 1'b1;
`else
  localparam bit RNE = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid0 = 1'b0, in_ready0, rm0 = 1'b0, out_valid0, out_ready0 = 1'b0, ovf0, inv0;
  logic [31:0] op0 = '0, res0;
  logic        in_valid1 = 1'b0, in_ready1, rm1 = 1'b0, out_valid1, out_ready1 = 1'b0, ovf1, inv1;
  logic [31:0] op1v = '0;
  logic [15:0] res1;

  ftoi_pipe #(.OUT_W(32), .STAGES(2)) u_dut0 (
    .clk(clk), .reset(reset), .in_valid(in_valid0), .in_ready(in_ready0), .op1(op0), .rm(rm0),
    .out_valid(out_valid0), .out_ready(out_ready0), .result(res0), .ovf(ovf0), .inv(inv0));

  ftoi_pipe #(.OUT_W(16), .STAGES(3)) u_dut1 (
    .clk(clk), .reset(reset), .in_valid(in_valid1), .in_ready(in_ready1), .op1(op1v), .rm(rm1),
    .out_valid(out_valid1), .out_ready(out_ready1), .result(res1), .ovf(ovf1), .inv(inv1));

  always #5 clk = ~clk;

  typedef struct { logic [31:0] res; logic ovf; logic inv; } exp_t;
  typedef struct { logic [31:0] op; logic r; logic [31:0] res_rne; logic ovf_rne;
                   logic [31:0] res_rtz; logic ovf_rtz; logic inv; } vec_t;

  exp_t q0[$], q1[$];
  int   n_pass = 0, n_tot = 0, nrdy0 = 0;
  bit   hold0 = 0, hold1 = 0, rnd0 = 0, rnd1 = 0;

  vec_t vt0 [18] = '{
    '{32'h40490FDB, 1'b0, 32'h00000003, 1'b0, 32'h00000003, 1'b0, 1'b0},
    '{32'hC0600000, 1'b1, 32'hFFFFFFFC, 1'b0, 32'hFFFFFFFD, 1'b0, 1'b0},
    '{32'hC0600000, 1'b0, 32'hFFFFFFFD, 1'b0, 32'hFFFFFFFD, 1'b0, 1'b0},
    '{32'h3F000000, 1'b1, 32'h00000000, 1'b0, 32'h00000000, 1'b0, 1'b0},
    '{32'h3FC00000, 1'b1, 32'h00000002, 1'b0, 32'h00000001, 1'b0, 1'b0},
    '{32'h3F400000, 1'b1, 32'h00000001, 1'b0, 32'h00000000, 1'b0, 1'b0},
    '{32'h40200000, 1'b1, 32'h00000002, 1'b0, 32'h00000002, 1'b0, 1'b0},
    '{32'h40600000, 1'b1, 32'h00000004, 1'b0, 32'h00000003, 1'b0, 1'b0},
    '{32'hBF7FFFFF, 1'b1, 32'hFFFFFFFF, 1'b0, 32'h00000000, 1'b0, 1'b0},
    '{32'h4EFFFFFF, 1'b0, 32'h7FFFFF80, 1'b0, 32'h7FFFFF80, 1'b0, 1'b0},
    '{32'hCEFFFFFF, 1'b1, 32'h80000080, 1'b0, 32'h80000080, 1'b0, 1'b0},
    '{32'h4F000000, 1'b0, 32'h7FFFFFFF, 1'b1, 32'h7FFFFFFF, 1'b1, 1'b0},
    '{32'hCF000000, 1'b0, 32'h80000000, 1'b0, 32'h80000000, 1'b0, 1'b0},
    '{32'h7FC00000, 1'b0, 32'h7FFFFFFF, 1'b0, 32'h7FFFFFFF, 1'b0, 1'b1},
    '{32'hFF800000, 1'b0, 32'h80000000, 1'b1, 32'h80000000, 1'b1, 1'b0},
    '{32'h80000000, 1'b1, 32'h00000000, 1'b0, 32'h00000000, 1'b0, 1'b0},
    '{32'h00000001, 1'b1, 32'h00000000, 1'b0, 32'h00000000, 1'b0, 1'b0},
    '{32'h4F7FFFFF, 1'b1, 32'h7FFFFFFF, 1'b1, 32'h7FFFFFFF, 1'b1, 1'b0}
  };

  vec_t vt1 [8] = '{
    '{32'h47000000, 1'b0, 32'h00007FFF, 1'b1, 32'h00007FFF, 1'b1, 1'b0},
    '{32'hC7000000, 1'b0, 32'h00008000, 1'b0, 32'h00008000, 1'b0, 1'b0},
    '{32'hC7000100, 1'b0, 32'h00008000, 1'b1, 32'h00008000, 1'b1, 1'b0},
    '{32'h46FFFE00, 1'b0, 32'h00007FFF, 1'b0, 32'h00007FFF, 1'b0, 1'b0},
    '{32'h46FFFF00, 1'b1, 32'h00007FFF, 1'b1, 32'h00007FFF, 1'b0, 1'b0},
    '{32'hC6FFFF00, 1'b1, 32'h00008000, 1'b0, 32'h00008001, 1'b0, 1'b0},
    '{32'h7FC00001, 1'b0, 32'h00007FFF, 1'b0, 32'h00007FFF, 1'b0, 1'b1},
    '{32'h4F000000, 1'b0, 32'h00007FFF, 1'b1, 32'h00007FFF, 1'b1, 1'b0}
  };

  logic [31:0] stream_ops [6] = '{32'h3F800000, 32'hC0300000, 32'h42C9CCCD,
                                  32'hC9742424, 32'h4B000001, 32'hBF000000};

  function automatic exp_t mk(input logic [31:0] res, input logic o, input logic i);
    exp_t x;
    x.res = res; x.ovf = o; x.inv = i;
    return x;
  endfunction

  function automatic exp_t pick(input vec_t v);
    return RNE ? mk(v.res_rne, v.ovf_rne, v.inv) : mk(v.res_rtz, v.ovf_rtz, v.inv);
  endfunction

  // Real-valued reference: decode float32, round magnitude, range-check.
  function automatic exp_t model(input logic [31:0] op, input logic r, input int ow);
    exp_t   x;
    real    m, t, fr, lim;
    longint v, maxv;
    int     ex;
    maxv = (longint'(1) <<< (ow - 1)) - 1;
    lim  = real'(maxv) + 1.0;
    x = mk('0, 1'b0, 1'b0);
    ex = int'(op[30:23]);
    if (ex == 255) begin
      if (op[22:0] != 0) x = mk(32'(maxv), 1'b0, 1'b1);
      else x = mk(op[31] ? 32'(-maxv - 1) : 32'(maxv), 1'b1, 1'b0);
      return x;
    end
    if (ex == 0) return x;
    m  = (1.0 + real'(op[22:0]) / 8388608.0) * (2.0 ** (ex - 127));
    t  = $floor(m);
    fr = m - t;
    if (r && (fr > 0.5 || (fr == 0.5 && (t / 2.0 - $floor(t / 2.0)) != 0.0))) t = t + 1.0;
    if ((!op[31] && t > lim - 1.0) || (op[31] && t > lim))
      x = mk(op[31] ? 32'(-maxv - 1) : 32'(maxv), 1'b1, 1'b0);
    else begin
      v = longint'(t);
      if (op[31]) v = -v;
      x.res = 32'(v);
    end
    return x;
  endfunction

  function automatic logic [31:0] rand_op();
    logic       s;
    logic [7:0] ex;
    s = 1'($urandom_range(1));
    case ($urandom_range(9))
      0: ex = 8'd0;
      1: ex = 8'd126;
      2: ex = 8'd125;
      3: return {s, 8'd158, 23'd0};
      default: ex = 8'($urandom_range(157, 127));
    endcase
    return {s, ex, 23'($urandom)};
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    n_tot++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got 0x%0h required 0x%0h", nm, act, req);
  endtask

  task automatic send(input int k, input logic [31:0] op, input logic r, input exp_t e);
    bit acc = 0;
    @(negedge clk);
    if (k == 0) begin in_valid0 = 1'b1; op0 = op; rm0 = r; end
    else begin in_valid1 = 1'b1; op1v = op; rm1 = r; end
    for (int n = 0; n < 200; n++) begin
      #3;
      if ((k == 0) ? in_ready0 : in_ready1) begin
        if (k == 0) q0.push_back(e); else q1.push_back(e);
        acc = 1;
        @(posedge clk);
        break;
      end
      if (k == 0) nrdy0++;
      @(negedge clk);
    end
    if (!acc) begin
      n_tot++;
      $display("FAIL send dut%0d: got in_ready low for 200 cycles required acceptance", k);
    end
  endtask

  task automatic idle(input int k);
    @(negedge clk);
    if (k == 0) in_valid0 = 1'b0; else in_valid1 = 1'b0;
  endtask

  task automatic drain(input int k);
    for (int n = 0; n < 2000; n++) begin
      if (((k == 0) ? q0.size() : q1.size()) == 0) break;
      @(negedge clk);
    end
    chk($sformatf("dut%0d drain pending", k), 64'((k == 0) ? q0.size() : q1.size()), 64'd0);
  endtask

  initial forever begin
    exp_t e;
    @(negedge clk); #1;
    out_ready0 = hold0 ? 1'b0 : (rnd0 ? ($urandom_range(3) != 0) : 1'b1);
    #1;
    if (out_valid0 && out_ready0) begin
      if (q0.size() == 0) begin
        n_tot++;
        $display("FAIL dut0 spurious: got result 0x%08h required none", res0);
      end else begin
        e = q0.pop_front();
        chk("dut0 {ovf,inv,result}", {30'd0, ovf0, inv0, res0}, {30'd0, e.ovf, e.inv, e.res});
      end
    end
  end

  initial forever begin
    exp_t e;
    @(negedge clk); #1;
    out_ready1 = hold1 ? 1'b0 : (rnd1 ? ($urandom_range(3) != 0) : 1'b1);
    #1;
    if (out_valid1 && out_ready1) begin
      if (q1.size() == 0) begin
        n_tot++;
        $display("FAIL dut1 spurious: got result 0x%04h required none", res1);
      end else begin
        e = q1.pop_front();
        chk("dut1 {ovf,inv,result}", {46'd0, ovf1, inv1, res1}, {46'd0, e.ovf, e.inv, e.res[15:0]});
      end
    end
  end

  initial begin
    logic [31:0] op;
    logic        r;
    #1 reset = 1'b0;
    #11;
    chk("reset out_valid0", 64'(out_valid0), 64'd0);
    chk("reset result0", 64'(res0), 64'd0);
    chk("reset flags0", {62'd0, ovf0, inv0}, 64'd0);
    chk("reset in_ready0", 64'(in_ready0), 64'd1);
    chk("reset out_valid1", 64'(out_valid1), 64'd0);
    @(negedge clk);
    reset = 1'b1;

    // Latency: STAGES=2 valid after N+1, STAGES=3 valid after N+2.
    send(0, 32'h40490FDB, 1'b0, mk(32'd3, 1'b0, 1'b0));
    idle(0); #2 chk("lat dut0 after N", 64'(out_valid0), 64'd0);
    @(negedge clk); #2 chk("lat dut0 after N+1", 64'(out_valid0), 64'd1);
    drain(0);
    send(1, 32'h42F60000, 1'b0, mk(32'd123, 1'b0, 1'b0));
    idle(1); #2 chk("lat dut1 after N", 64'(out_valid1), 64'd0);
    @(negedge clk); #2 chk("lat dut1 after N+1", 64'(out_valid1), 64'd0);
    @(negedge clk); #2 chk("lat dut1 after N+2", 64'(out_valid1), 64'd1);
    drain(1);

    foreach (vt0[i]) send(0, vt0[i].op, vt0[i].r, pick(vt0[i]));
    idle(0); drain(0);
    foreach (vt1[i]) send(1, vt1[i].op, vt1[i].r, pick(vt1[i]));
    idle(1); drain(1);

    // Back-to-back stream with a 3-cycle output stall in the middle.
    nrdy0 = 0;
    fork
      begin
        foreach (stream_ops[i]) send(0, stream_ops[i], 1'b0, model(stream_ops[i], 1'b0, 32));
        idle(0);
      end
      begin
        repeat (3) @(negedge clk);
        hold0 = 1'b1;
        repeat (3) @(negedge clk);
        hold0 = 1'b0;
      end
    join
    drain(0);
    chk("stream in_ready dropped", 64'(nrdy0 > 0), 64'd1);

    // Reset mid-cycle with two ops in flight.
    hold0 = 1'b1;
    send(0, 32'h40A00000, 1'b0, mk(32'd5, 1'b0, 1'b0));
    send(0, 32'h41200000, 1'b0, mk(32'd10, 1'b0, 1'b0));
    idle(0);
    #3 reset = 1'b0;
    #1;
    chk("inflight reset out_valid0", 64'(out_valid0), 64'd0);
    chk("inflight reset result0", 64'(res0), 64'd0);
    q0.delete();
    @(negedge clk);
    reset = 1'b1;
    hold0 = 1'b0;
    send(0, 32'h42F60000, 1'b0, mk(32'd123, 1'b0, 1'b0));
    idle(0); drain(0);

    rnd0 = 1'b1;
    repeat (10000) begin
      op = rand_op(); r = 1'($urandom_range(1));
      send(0, op, r, model(op, r & RNE, 32));
    end
    idle(0); drain(0);
    rnd0 = 1'b0;

    rnd1 = 1'b1;
    repeat (3000) begin
      op = rand_op(); r = 1'($urandom_range(1));
      send(1, op, r, model(op, r & RNE, 16));
    end
    idle(1); drain(1);
    rnd1 = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule

// File: doc/ftoi_pipe.md
Name: ftoi_pipe

Overview:
- Parametrised, pipelined IEEE-754 single-precision to signed-integer converter; next generation of the FPU ftoi unit.
- Adds configurable output width and pipeline depth, valid/ready handshake with backpressure, selectable rounding, saturation and exception flags.
- Sits in the FPU execute path beside the other converters; feeds the integer writeback mux.

Parameters:
- OUT_W, 32, signed result width (16..32).
- STAGES, 2, pipeline depth (1..4); latency in cycles with no stall.

Ports:
- clk  input  1  clock, rising edge
- reset  input  1  asynchronous, active-low reset
- in_valid  input  1  op1/rm valid
- in_ready  output  1  converter accepts op1 this cycle
- op1  input  32  float32 operand
- rm  input  1  rounding mode: 0 = RTZ (truncate), 1 = RNE
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts result
- result  output  OUT_W  signed integer result
- ovf  output  1  overflow; result saturated
- inv  output  1  NaN input

Behaviour:
- Reset (reset=0, async): all stage valid bits, out_valid, result, ovf and inv go to 0 immediately. In-flight data is discarded. First acceptance is possible on the first rising edge after release.
- Handshake:
  - advance = !out_valid || out_ready; in_ready = advance.
  - Transfer in when in_valid && in_ready; transfer out when out_valid && out_ready.
  - When advance=0 every stage holds.
  - Bubbles are not squeezed; a valid bit travels with each stage.
  - A simultaneous accept and drain on the same edge is legal and sustains 1 result/cycle.
- Latency: an op accepted at edge N appears with out_valid=1 after edge N+STAGES-1 when unstalled. STAGES=1 means result valid the cycle after acceptance.
- Stage split:
  - S1 decodes fields: s, e=exp-127, mant={1,frac}. It shifts mant to integer magnitude plus guard and sticky bits.
  - Last stage rounds, negates and saturates.
  - Extra stages (STAGES>2) are pure register slices inserted before the last stage.
  - With STAGES=1 both steps are combinational into one register.
- Arithmetic:
  - exp==0 (zero/denormal) gives 0, flags 0 (denormals flushed).
  - e<0: RTZ gives 0. RNE gives magnitude 1 if e==-1 and frac!=0; otherwise 0 (±0.5 rounds to 0).
  - RNE ties go to the even value; sticky is the OR of all discarded bits below guard.
  - Magnitude limit is 2^(OUT_W-1)-1 positive, 2^(OUT_W-1) negative. Exceeding it (after rounding) gives a saturated result (0x7FFF.. or 0x800..) with ovf=1.
  - Exactly -2^(OUT_W-1) gives min with ovf=0.
  - Inf saturates by sign, ovf=1.
  - NaN gives max positive, inv=1, ovf=0.
  - Negative zero gives 0.
- ovf and inv are per-result; valid only with out_valid.
- rm is sampled with op1 and travels with it.

Optional Feature:
- FTOI_RNE_EN.
- Defined: rm honoured as above.
- Undefined: rm is ignored, all conversions use RTZ, and the guard/sticky logic is removed. Port list is unchanged.

Decomposition:
- fpu_pkg (shared) holds:
  - rm_t enum {RM_RTZ, RM_RNE}
  - float32 field constants (EXP_W=8, FRAC_W=23, BIAS=127)
  - f32_t struct {sign, exp, frac}
  - the S1-to-last-stage payload struct
- One sub-module: ftoi_round (combinational round/negate/saturate). It is instantiated in the last stage; the pipeline registers and handshake live in ftoi_pipe.

Test Plan:
- STAGES=2, RTZ, op1=0x40490FDB (3.14159) accepted at edge N -> out_valid after edge N+1, result=3, flags 0.
- RNE: 0xC0600000 (-3.5) -> 0xFFFFFFFC (-4); RTZ -> 0xFFFFFFFD (-3). RNE on 0x3F000000 (0.5) -> 0; RNE on 0x3FC00000 (1.5) -> 2.
- 0x4F000000 (2^31) -> 0x7FFFFFFF, ovf=1. 0xCF000000 (-2^31) -> 0x80000000, ovf=0. 0x7FC00000 -> 0x7FFFFFFF, inv=1. 0xFF800000 -> 0x80000000, ovf=1.
- Stream 6 ops back-to-back with out_ready held 0 for 3 cycles mid-stream:
  - in_ready drops while the pipeline is full.
  - No loss or duplication; order is preserved.
  - Results match a $rtoi reference for RTZ.
- Assert reset low between clock edges with 2 ops in flight -> out_valid=0 and result=0 immediately. After release, a new op 0x42F60000 (123.0) yields 123.
- 10k random op1 values within ±2^31, both rm, random out_ready -> results match a real-valued model. Repeat with OUT_W=16: out-of-range values saturate to 0x7FFF/0x8000 with ovf=1.
